// File: rtl/sha256_pkg.sv
// Constants and helpers shared by the SHA-256 front end.
// The padder packs the message into 16-word blocks and replays each block as a 64-cycle burst.
package sha256_pkg;
  localparam int          BLOCK_WORDS = 16;
  localparam int          BURST_LEN   = 64;
  localparam int          LEN_W       = 64;
  localparam logic [31:0] PAD_MARKER  = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_PAD2,
    ST_EMIT,
    ST_GAP
  } pad_state_t;

  // Keep the first n bytes of a word and put the 0x80 marker right after them.
  // When n is 4 the word is full, so it is returned unchanged.
  function automatic logic [31:0] mark_last_word(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    return PAD_MARKER;
      3'd1:    return {d[31:24], 24'h80_0000};
      3'd2:    return {d[31:16], 16'h8000};
      3'd3:    return {d[31:8], 8'h80};
      default: return d;
    endcase
  endfunction
endpackage

// File: rtl/sha256_block_buf.sv
// 16x32 block buffer: one synchronous write port and one combinational read port.
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [3:0]  i_widx,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_ridx,
  output logic [31:0] o_rdata
);
  logic [31:0] r_mem [BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: fills 512-bit blocks from a word stream, applies the padding,
// and replays each finished block to the schedule as an uninterrupted 64-cycle burst.
//  state | meaning
//  IDLE  | waiting for the first word of a message (in_ready=1)
//  FILL  | accepting message words into the buffer (in_ready=1)
//  PAD   | marker / zero fill / length words after the last message word
//  PAD2  | extra block: zero fill plus length (marker may still be pending)
//  EMIT  | 64-cycle burst; words 0..15 on data with write_enable
//  GAP   | GAP_CYCLES idle cycles after each burst
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_in_data,
  input  logic        i_in_valid,
  input  logic        i_in_last,
  input  logic [2:0]  i_in_nbytes,
  output logic        o_in_ready,
  output logic [31:0] o_data,
  output logic        o_write_enable,
  output logic        o_inner_busy,
  output logic        o_block_first,
  output logic        o_block_last,
  output logic        o_msg_done
);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
  localparam logic [5:0] K_LAST   = 6'(BURST_LEN - 1);

  pad_state_t r_state, w_next;
  logic [3:0]  r_idx;
  logic [5:0]  r_k;
  logic [7:0]  r_gap;
  logic [60:0] r_bytes;
  logic        r_in_ready;
  logic        r_mark_pend;
  logic        r_more;
  logic        r_final;
  logic        r_first;

  logic             w_acc;
  logic             w_we;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rdata;
  logic [2:0]       w_n;
  logic [LEN_W-1:0] w_len;

  assign w_acc = r_in_ready & i_in_valid;
  assign w_n   = (i_in_last && i_in_nbytes < 3'd4) ? i_in_nbytes : 3'd4;
  assign w_len = {r_bytes, 3'b000};

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_wdata = '0;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_acc) begin
          w_we    = 1'b1;
          w_wdata = mark_last_word(i_in_data, w_n);
          if (r_idx == 4'd15)  w_next = ST_EMIT;
          else if (i_in_last)  w_next = ST_PAD;
          else                 w_next = ST_FILL;
        end
      end
      ST_PAD, ST_PAD2: begin
        // Reaching word 14 with no marker pending means the marker sits at 13 or below,
        // so the length fits in this block.
        w_we = 1'b1;
        if (r_mark_pend)                    w_wdata = PAD_MARKER;
        else if (r_idx == 4'd14)            w_wdata = w_len[63:32];
        else if (r_idx == 4'd15 && r_final) w_wdata = w_len[31:0];
        if (r_idx == 4'd15) w_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (r_k == K_LAST) w_next = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap == '0) w_next = r_final ? ST_IDLE : (r_more ? ST_FILL : ST_PAD2);
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_k         <= '0;
      r_gap       <= '0;
      r_bytes     <= '0;
      r_in_ready  <= 1'b0;
      r_mark_pend <= 1'b0;
      r_more      <= 1'b0;
      r_final     <= 1'b0;
      r_first     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == ST_IDLE) || (w_next == ST_FILL);
      if (w_we) r_idx <= r_idx + 4'd1;
      if (w_acc) begin
        r_bytes     <= ((r_state == ST_IDLE) ? '0 : r_bytes) + 61'(w_n);
        r_more      <= !i_in_last;
        r_mark_pend <= i_in_last && (w_n == 3'd4);
        if (r_state == ST_IDLE) begin
          r_first <= 1'b1;
          r_final <= 1'b0;
        end
      end
      if (r_state == ST_PAD || r_state == ST_PAD2) begin
        if (r_mark_pend)          r_mark_pend <= 1'b0;
        else if (r_idx == 4'd14)  r_final     <= 1'b1;
      end
      if (r_state == ST_EMIT) begin
        r_k <= r_k + 6'd1;
        if (r_k == K_LAST) begin
          r_gap   <= GAP_LOAD;
          r_first <= 1'b0;
        end
      end
      if (r_state == ST_GAP) r_gap <= r_gap - 8'd1;
    end
  end

  sha256_block_buf u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (w_wdata),
    .i_ridx  (r_k[3:0]),
    .o_rdata (w_rdata)
  );

  assign o_in_ready     = r_in_ready;
  assign o_inner_busy   = (r_state == ST_EMIT);
  assign o_write_enable = o_inner_busy && (r_k[5:4] == 2'b00);
  assign o_data         = o_write_enable ? w_rdata : '0;
  assign o_block_first  = o_inner_busy && (r_k == '0) && r_first;
  assign o_block_last   = o_inner_busy && (r_k == '0) && r_final;
  assign o_msg_done     = (r_state == ST_GAP) && (r_gap == '0) && r_final;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Testbench for sha256_msg_padder: fixed vectors with hand-computed words, random messages
// checked against a byte-level SHA-256 padding model, and a reset-mid-burst sequence.
module tb_sha256_msg_padder;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_in_data = '0;
  logic        i_in_valid = 1'b0;
  logic        i_in_last = 1'b0;
  logic [2:0]  i_in_nbytes = '0;
  logic        o_in_ready;
  logic [31:0] o_data;
  logic        o_write_enable;
  logic        o_inner_busy;
  logic        o_block_first;
  logic        o_block_last;
  logic        o_msg_done;

  always #5 clk = ~clk;

  sha256_msg_padder #(.GAP_CYCLES(GAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_in_data      (i_in_data),
    .i_in_valid     (i_in_valid),
    .i_in_last      (i_in_last),
    .i_in_nbytes    (i_in_nbytes),
    .o_in_ready     (o_in_ready),
    .o_data         (o_data),
    .o_write_enable (o_write_enable),
    .o_inner_busy   (o_inner_busy),
    .o_block_first  (o_block_first),
    .o_block_last   (o_block_last),
    .o_msg_done     (o_msg_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Burst monitor
  logic [31:0] cap_w[$];
  logic        cap_f[$];
  logic        cap_l[$];
  logic        cap_ok[$];
  logic [31:0] cur_w[16];
  logic        cur_f, cur_l, cur_ok, last_final;
  int          bcnt = 0;
  int          idle_cnt = 1000;
  bit          had_burst = 0;
  int          done_cnt = 0;
  int          done_idle = 0;
  bit          done_after_final = 0;
  bit          quiet_bad = 0;

  task automatic push_burst(input logic ok);
    for (int i = 0; i < 16; i++) cap_w.push_back(cur_w[i]);
    cap_f.push_back(cur_f);
    cap_l.push_back(cur_l);
    cap_ok.push_back(ok);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      bcnt      = 0;
      had_burst = 0;
      idle_cnt  = 1000;
    end else if (o_inner_busy) begin
      if (bcnt == 0) begin
        cur_f  = o_block_f_w();
        cur_l  = o_block_last;
        cur_ok = !(had_burst && idle_cnt < GAP);
        for (int i = 0; i < 16; i++) cur_w[i] = 'x;
      end else if (o_block_first || o_block_last) begin
        cur_ok = 1'b0;
      end
      if (o_write_enable != (bcnt < 16)) cur_ok = 1'b0;
      if (bcnt < 16) cur_w[bcnt] = o_data;
      else if (o_data != '0) cur_ok = 1'b0;
      if (o_in_ready || o_msg_done) cur_ok = 1'b0;
      bcnt++;
      if (bcnt == 64) begin
        push_burst(cur_ok);
        bcnt       = 0;
        had_burst  = 1;
        idle_cnt   = 0;
        last_final = cur_l;
      end
    end else begin
      if (bcnt != 0) begin
        push_burst(1'b0);
        bcnt = 0;
      end
      idle_cnt++;
      if (o_write_enable || o_data != '0 || o_block_first || o_block_last) quiet_bad = 1;
      if (o_msg_done) begin
        done_cnt++;
        done_idle        = idle_cnt;
        done_after_final = last_final;
      end
    end
  end

  function automatic logic o_block_f_w();
    return o_block_first;
  endfunction

  // Reference model: plain SHA-256 padding on a byte array
  logic [7:0]  msg[$];
  logic [31:0] exp_w[$];

  task automatic ref_model();
    logic [7:0]  p[$];
    logic [63:0] bl;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    exp_w.delete();
    for (int i = 0; i < p.size(); i += 4) exp_w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit acc;
    int t;
    i_in_data   = d;
    i_in_valid  = 1'b1;
    i_in_last   = last;
    i_in_nbytes = nb;
    acc = 0;
    t = 0;
    while (!acc && t < 400) begin
      @(negedge clk);
      acc = o_in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no handshake in %0d cycles expected in_ready", t);
    end
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  // vmode 0: back-to-back, 1: valid toggles every other cycle, 2: random idle gaps
  task automatic send_msg(input int vmode);
    int nw, nb;
    logic [31:0] d;
    nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    for (int j = 0; j < nw; j++) begin
      d  = $urandom;
      nb = msg.size() - 4 * j;
      if (nb > 4) nb = 4;
      for (int b = 0; b < nb; b++) d[31-8*b -: 8] = msg[4*j+b];
      if (vmode == 1) begin
        @(posedge clk);
        #1;
      end else if (vmode == 2 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_word(d, j == nw - 1, (j == nw - 1) ? 3'(nb) : 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic run_msg(input int vmode);
    int t, nb;
    cap_w.delete();
    cap_f.delete();
    cap_l.delete();
    cap_ok.delete();
    done_cnt  = 0;
    quiet_bad = 0;
    ref_model();
    send_msg(vmode);
    t = 0;
    while (done_cnt == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    nb = exp_w.size() / 16;
    chk("msg_done_count", done_cnt, 1);
    chk("msg_done_gap", done_idle, GAP);
    chk("msg_done_after_final", done_after_final, 1);
    chk("idle_outputs_quiet", quiet_bad, 0);
    chk("burst_count", cap_f.size(), nb);
    for (int b = 0; b < cap_f.size() && b < nb; b++) begin
      chk($sformatf("b%0d_first", b), cap_f[b], b == 0);
      chk($sformatf("b%0d_last", b), cap_l[b], b == nb - 1);
      chk($sformatf("b%0d_shape", b), cap_ok[b], 1);
      for (int i = 0; i < 16; i++)
        chk($sformatf("b%0d_w%0d", b, i), cap_w[16*b+i], exp_w[16*b+i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic build_msg(input int len, input int pat);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(pat == 0 ? 8'(8'h61 + i) : 8'(i + 1));
  endtask

  typedef struct packed {
    int len;
    int pat;
    int vmode;
    int nblk;
  } vec_t;

  typedef struct packed {
    int          v;
    int          blk;
    int          idx;
    logic [31:0] val;
  } wchk_t;

  localparam int NV = 8;
  localparam int NC = 27;
  vec_t  vecs[NV];
  wchk_t chks[NC];

  task automatic run_vec(input int v);
    logic [31:0] w;
    int pos;
    build_msg(vecs[v].len, vecs[v].pat);
    run_msg(vecs[v].vmode);
    chk($sformatf("v%0d_nblk", v), cap_f.size(), vecs[v].nblk);
    for (int c = 0; c < NC; c++) begin
      if (chks[c].v == v) begin
        pos = 16 * chks[c].blk + chks[c].idx;
        w = (pos < cap_w.size()) ? cap_w[pos] : 'x;
        chk($sformatf("v%0d_b%0d_w%0d", v, chks[c].blk, chks[c].idx), w, chks[c].val);
      end
    end
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, len, vm;
    // {len, pattern (0 = "abc..", 1 = byte i is i+1), valid mode, blocks}
    vecs[0] = '{3,   0, 0, 1};
    vecs[1] = '{0,   1, 0, 1};
    vecs[2] = '{55,  1, 2, 1};
    vecs[3] = '{56,  1, 0, 2};
    vecs[4] = '{64,  1, 1, 2};
    vecs[5] = '{4,   1, 0, 1};
    vecs[6] = '{62,  1, 0, 2};
    vecs[7] = '{120, 1, 2, 3};
    chks[0]  = '{0, 0, 0,  32'h6162_6380};
    chks[1]  = '{0, 0, 1,  32'h0000_0000};
    chks[2]  = '{0, 0, 15, 32'h0000_0018};
    chks[3]  = '{1, 0, 0,  32'h8000_0000};
    chks[4]  = '{1, 0, 15, 32'h0000_0000};
    chks[5]  = '{2, 0, 13, 32'h3536_3780};
    chks[6]  = '{2, 0, 14, 32'h0000_0000};
    chks[7]  = '{2, 0, 15, 32'h0000_01B8};
    chks[8]  = '{3, 0, 13, 32'h3536_3738};
    chks[9]  = '{3, 0, 14, 32'h8000_0000};
    chks[10] = '{3, 0, 15, 32'h0000_0000};
    chks[11] = '{3, 1, 0,  32'h0000_0000};
    chks[12] = '{3, 1, 15, 32'h0000_01C0};
    chks[13] = '{4, 0, 0,  32'h0102_0304};
    chks[14] = '{4, 0, 15, 32'h3D3E_3F40};
    chks[15] = '{4, 1, 0,  32'h8000_0000};
    chks[16] = '{4, 1, 14, 32'h0000_0000};
    chks[17] = '{4, 1, 15, 32'h0000_0200};
    chks[18] = '{5, 0, 0,  32'h0102_0304};
    chks[19] = '{5, 0, 1,  32'h8000_0000};
    chks[20] = '{5, 0, 15, 32'h0000_0020};
    chks[21] = '{6, 0, 15, 32'h3D3E_8000};
    chks[22] = '{6, 1, 0,  32'h0000_0000};
    chks[23] = '{6, 1, 15, 32'h0000_01F0};
    chks[24] = '{7, 1, 0,  32'h4142_4344};
    chks[25] = '{7, 1, 14, 32'h8000_0000};
    chks[26] = '{7, 2, 15, 32'h0000_03C0};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o_in_ready, o_inner_busy, o_write_enable, o_block_first,
                          o_block_last, o_msg_done, o_data}, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", o_in_ready, 0);
    @(negedge clk);
    chk("idle_ready", o_in_ready, 1);
    @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) run_vec(v);

    // Reset during burst cycle 30 aborts the burst; a fresh "abc" then repeats vector 0.
    build_msg(3, 0);
    send_msg(0);
    t = 0;
    @(negedge clk);
    while (!o_inner_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_burst_started", o_inner_busy, 1);
    repeat (29) @(negedge clk);
    chk("abort_busy_cycle29", {o_inner_busy, o_write_enable}, 2'b10);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {o_inner_busy, o_write_enable, o_in_ready}, 3'b000);
    @(negedge clk);
    chk("abort_idle_ready", o_in_ready, 1);
    @(posedge clk);
    #1;
    run_vec(0);

    for (int r = 0; r < 24; r++) begin
      if (r % 4 == 0) len = 64 * $urandom_range(0, 2) + 52 + $urandom_range(0, 12);
      else            len = $urandom_range(0, 150);
      vm = $urandom_range(0, 2);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg(vm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
